prog_loader_arb: RTL



---
 rtl/prog_loader_arb.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/prog_loader_arb.sv
// Memory-port arbiter and program sequencer: host streams an image in,
// reads it back to verify, then releases the core for a bounded run.
module prog_loader_arb #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  host_start,
    input  logic [ADDR_WIDTH-1:0] host_base,
    input  logic [ADDR_WIDTH-1:0] host_len,
    input  logic [CNT_WIDTH-1:0]  host_run_cycles,
    input  logic                  host_valid,
    input  logic [DATA_WIDTH-1:0] host_data,
    output logic                  host_ready,
    input  logic                  host_halt,
    input  logic                  host_rd_req,
    input  logic [ADDR_WIDTH-1:0] host_rd_addr,
    output logic                  host_rd_valid,
    output logic [DATA_WIDTH-1:0] host_rd_data,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic                  core_we,
    input  logic [DATA_WIDTH-1:0] core_din,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  core_reset_n,
    output logic [2:0]            state,
    output logic [DATA_WIDTH-1:0] checksum,
    output logic                  verify_err,
    output logic                  done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_VERIFY = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    localparam logic [CNT_WIDTH-1:0] RUN_ONE = 1;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic [CNT_WIDTH-1:0]  run_q, run_d;
    // One extra bit so VERIFY can count through len+1
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] csum_q, csum_d;
    logic [DATA_WIDTH-1:0] vsum_q, vsum_d;
    logic                  verr_q, verr_d;
    logic                  crn_q, crn_d;
    logic                  rdv_q, rdv_d;

    logic [ADDR_WIDTH:0]   len_x;
    logic [ADDR_WIDTH:0]   cnt_inc;

    assign len_x   = {1'b0, len_q};
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        run_d    = run_q;
        cnt_d    = cnt_q;
        csum_d   = csum_q;
        vsum_d   = vsum_q;
        verr_d   = verr_q;
        rdv_d    = 1'b0;
        mem_addr = '0;
        mem_we   = 1'b0;
        mem_din  = '0;
        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (host_start) begin
                    base_d  = host_base;
                    len_d   = host_len;
                    run_d   = host_run_cycles;
                    cnt_d   = '0;
                    csum_d  = '0;
                    vsum_d  = '0;
                    verr_d  = 1'b0;
                    state_d = (host_len != '0) ? S_LOAD : S_RUN;
                end else if (host_rd_req) begin
                    mem_addr = host_rd_addr;
                    rdv_d    = 1'b1;
                end
            end
            S_LOAD: begin
                if (host_valid) begin
                    mem_we   = 1'b1;
                    mem_addr = base_q + cnt_q[ADDR_WIDTH-1:0];
                    mem_din  = host_data;
                    csum_d   = csum_q ^ host_data;
                    cnt_d    = cnt_inc;
                    if (cnt_inc == len_x) begin
                        cnt_d   = '0;
                        state_d = S_VERIFY;
                    end
                end
            end
            S_VERIFY: begin
                if (cnt_q < len_x) begin
                    mem_addr = base_q + cnt_q[ADDR_WIDTH-1:0];
                end
                // Read i returns in cycle i+1
                if (cnt_q != '0 && cnt_q <= len_x) begin
                    vsum_d = vsum_q ^ mem_dout;
                end
                if (cnt_q == len_x + 1'b1) begin
                    cnt_d = '0;
                    if (vsum_q != csum_q) begin
                        verr_d  = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RUN: begin
                mem_addr = core_addr;
                mem_we   = core_we;
                mem_din  = core_din;
                if (run_q != '0) begin
                    run_d = run_q - 1'b1;
                end
                if (host_halt) begin
                    state_d = S_HALT;
                end else if (run_q == RUN_ONE) begin
                    state_d = S_HALT;
                end
            end
            default: state_d = S_IDLE;
        endcase
        crn_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            run_q   <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
            vsum_q  <= '0;
            verr_q  <= 1'b0;
            crn_q   <= 1'b0;
            rdv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            run_q   <= run_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            vsum_q  <= vsum_d;
            verr_q  <= verr_d;
            crn_q   <= crn_d;
            rdv_q   <= rdv_d;
        end
    end

    assign host_ready    = (state_q == S_LOAD);
    assign host_rd_valid = rdv_q;
    assign host_rd_data  = rdv_q ? mem_dout : '0;
    assign core_reset_n  = crn_q;
    assign state         = state_q;
    assign checksum      = csum_q;
    assign verify_err    = verr_q;
    assign done          = (state_q == S_HALT);

endmodule
